// File: rtl/csr_intr_unit_if.sv
// CSR access and interrupt signalling between the control-unit FSM (master)
// and the machine-mode CSR / interrupt unit (slave).
interface csr_intr_unit_if;
  logic        INTR_EXT;
  logic        CSR_WR;
  logic        INT_TAKEN;
  logic        MRET_EXEC;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_WD;
  logic [31:0] PC;
  logic [31:0] CSR_RD;
  logic [31:0] MTVEC_OUT;
  logic [31:0] MEPC_OUT;
  logic        CSR_MIE;
  logic        INTR;

  modport master (
    output INTR_EXT, CSR_WR, INT_TAKEN, MRET_EXEC, CSR_ADDR, CSR_WD, PC,
    input  CSR_RD, MTVEC_OUT, MEPC_OUT, CSR_MIE, INTR
  );

  modport slave (
    input  INTR_EXT, CSR_WR, INT_TAKEN, MRET_EXEC, CSR_ADDR, CSR_WD, PC,
    output CSR_RD, MTVEC_OUT, MEPC_OUT, CSR_MIE, INTR
  );
endinterface

// File: rtl/csr_intr_unit.sv
// Machine-mode CSR file (mstatus, mtvec, mepc, mcause, mip) and external
// interrupt synchroniser / pending latch for the multicycle RV32 core.
module csr_intr_unit #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MCAUSE_EXT  = 32'h8000000B
) (
  input logic            CLK,
  input logic            RST,
  csr_intr_unit_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] fill_r;   // ones shift in behind reset: marks real samples
  logic                   hist_r;
  logic                   armed_r;  // a real low sample has been seen since reset
  logic                   pending_r;
  logic                   mie_r;
  logic                   mpie_r;
  logic [31:0]            mtvec_r;
  logic [31:0]            mepc_r;
  logic [31:0]            mcause_r;
  logic                   sync_out_s;
  logic                   rise_s;
  logic [31:0]            rd_s;

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  // Only rising edges seen after a genuine low sample count, so a line that
  // stays high across reset cannot produce a spurious edge.
  assign rise_s     = sync_out_s & ~hist_r & armed_r;

  // Synchronise the external line, keep one history flop, and arm edge detect
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_r  <= '0;
      fill_r  <= '0;
      hist_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], bus.INTR_EXT};
      fill_r  <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      hist_r  <= sync_out_s;
      armed_r <= armed_r | (fill_r[SYNC_STAGES-1] & ~sync_out_s);
    end
  end

  // Pending latch: a new edge sets it (winning over entry), entry clears it
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_r <= 1'b0;
    end else if (rise_s) begin
      pending_r <= 1'b1;
    end else if (bus.INT_TAKEN) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // CSR state: mtvec writes are independent; entry > MRET > write for the rest
  always_ff @(posedge CLK) begin
    if (RST) begin
      mie_r    <= 1'b0;
      mpie_r   <= 1'b0;
      mtvec_r  <= 32'h0;
      mepc_r   <= 32'h0;
      mcause_r <= 32'h0;
    end else begin
      if (bus.CSR_WR && (bus.CSR_ADDR == ADDR_MTVEC)) begin
        mtvec_r <= bus.CSR_WD & 32'hFFFF_FFFC;
      end
      if (bus.INT_TAKEN) begin
        mepc_r   <= bus.PC & 32'hFFFF_FFFC;
        mcause_r <= MCAUSE_EXT;
        mpie_r   <= mie_r;
        mie_r    <= 1'b0;
      end else if (bus.MRET_EXEC) begin
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
      end else if (bus.CSR_WR) begin
        case (bus.CSR_ADDR)
          ADDR_MSTATUS: begin
            mie_r  <= bus.CSR_WD[3];
            mpie_r <= bus.CSR_WD[7];
          end
          ADDR_MEPC:   mepc_r   <= bus.CSR_WD & 32'hFFFF_FFFC;
          ADDR_MCAUSE: mcause_r <= bus.CSR_WD;
          default:     ;
        endcase
      end
    end
  end

  // Combinational read mux showing pre-write register state
  always_comb begin
    rd_s = 32'h0;
    case (bus.CSR_ADDR)
      ADDR_MSTATUS: rd_s = {24'h0, mpie_r, 3'b000, mie_r, 3'b000};
      ADDR_MTVEC:   rd_s = mtvec_r;
      ADDR_MEPC:    rd_s = mepc_r;
      ADDR_MCAUSE:  rd_s = mcause_r;
      ADDR_MIP:     rd_s = {20'h0, pending_r, 11'h0};
      default:      rd_s = 32'h0;
    endcase
  end

  assign bus.CSR_RD    = rd_s;
  assign bus.MTVEC_OUT = mtvec_r;
  assign bus.MEPC_OUT  = mepc_r;
  assign bus.CSR_MIE   = mie_r;
  assign bus.INTR      = pending_r & mie_r;

endmodule
